// File: rtl/fir_pkg.sv
// Shared definitions for the FIR lane sequencer: FSM state encoding,
// tap-length clamping and run-length arithmetic.
package fir_pkg;

  localparam int TAP_W   = 12;
  localparam int PCM_W   = 16;
  localparam int SHIFT_W = 4;
  localparam int RUN_W   = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_HOLD
  } state_t;

  // A zero tap count still needs one tap; anything past the ring depth is
  // limited to the deepest history the ring can hold.
  function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] len,
                                                 input int unsigned      aw);
    logic [31:0] lim;
    lim = (32'd1 << aw) - 32'd1;
    if (len == '0)
      return TAP_W'(1);
    else if (aw < TAP_W && 32'(len) > lim)
      return TAP_W'(lim);
    else
      return len;
  endfunction

  function automatic logic [RUN_W-1:0] run_len(input logic [TAP_W-1:0] tap,
                                               input int unsigned      mul,
                                               input int unsigned      lat);
    logic [31:0] cycles;
    cycles = (32'(tap) + mul - 32'd1) / mul + lat - 32'd1;
    return RUN_W'(cycles);
  endfunction

endpackage

// File: rtl/fir_lane_seq.sv
// Sequencer for one fir_lane: accepts a PCM sample, writes it into the lane
// ring, holds the lane start high for the run length and returns the result.
module fir_lane_seq
  import fir_pkg::*;
#(
  parameter int unsigned PCMAW   = 9,
  parameter int unsigned MUL_NUM = 2,
  parameter int unsigned FIR_LAT = 8
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               flush,
  input  logic [TAP_W-1:0]   cfg_tap_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               s_valid,
  input  logic [PCM_W-1:0]   s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic [PCM_W-1:0]   m_data,
  output logic               m_warm,
  input  logic               m_ready,
  output logic               pcm_in_wr,
  output logic [PCM_W-1:0]   pcm_in,
  output logic [PCMAW-1:0]   pcm_in_address,
  output logic [SHIFT_W-1:0] pcm_out_shift,
  output logic [TAP_W-1:0]   tap_len,
  output logic               fir_start,
  input  logic [PCM_W-1:0]   pcm_out
);

  localparam logic [PCMAW-1:0] FILL_MAX = '1;

  state_t state, state_next;

  logic               s_ready_q;
  logic               flush_pend, flush_pend_next;
  logic [PCMAW-1:0]   wr_ptr;
  logic [PCMAW-1:0]   fill;
  logic [PCM_W-1:0]   sample;
  logic [TAP_W-1:0]   tap_eff;
  logic [SHIFT_W-1:0] shift;
  logic [RUN_W-1:0]   run_cnt;

  logic accept;
  logic do_flush;
  logic capture;
  logic done_ack;

  always_ff @(posedge clk1) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    do_flush   = 1'b0;
    capture    = 1'b0;
    done_ack   = 1'b0;
    pcm_in_wr  = 1'b0;
    fir_start  = 1'b0;
    m_valid    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (flush || flush_pend) begin
          do_flush = 1'b1;
        end else if (s_valid && s_ready_q) begin
          accept     = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pcm_in_wr  = 1'b1;
        state_next = ST_START;
      end
      ST_START: begin
        fir_start  = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        fir_start = 1'b1;
        // run_cnt holds the RUN cycles still to go; this is the last one.
        if (run_cnt <= RUN_W'(1)) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          done_ack   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A flush seen outside IDLE waits here; IDLE always consumes it.
  assign flush_pend_next = (state == ST_IDLE) ? 1'b0 : (flush_pend | flush);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk1) begin
    if (rst) begin
      s_ready_q  <= 1'b1;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      fill       <= '0;
      sample     <= '0;
      tap_eff    <= TAP_W'(1);
      shift      <= '0;
      run_cnt    <= '0;
      m_data     <= '0;
      m_warm     <= 1'b0;
    end else begin
      s_ready_q  <= (state_next == ST_IDLE) && !flush_pend_next;
      flush_pend <= flush_pend_next;

      if (do_flush) begin
        wr_ptr <= '0;
        fill   <= '0;
      end else if (done_ack) begin
        wr_ptr <= wr_ptr + PCMAW'(1);
        if (fill != FILL_MAX) fill <= fill + PCMAW'(1);
      end

      if (accept) begin
        sample  <= s_data;
        tap_eff <= clamp_tap(cfg_tap_len, PCMAW);
        shift   <= cfg_shift;
      end

      if (state == ST_START)
        run_cnt <= run_len(tap_eff, MUL_NUM, FIR_LAT);
      else if (state == ST_RUN)
        run_cnt <= run_cnt - RUN_W'(1);

      if (capture) begin
        m_data <= pcm_out;
        m_warm <= (32'(fill) + 32'd1) >= 32'(tap_eff);
      end
    end
  end

  assign s_ready        = s_ready_q;
  assign pcm_in         = sample;
  assign pcm_in_address = wr_ptr;
  assign tap_len        = tap_eff;
  assign pcm_out_shift  = shift;

endmodule

// File: tb/tb_fir_lane_seq.sv
// Directed bench for fir_lane_seq: a 9-bit-ring instance for timing, clamp,
// flush and reset cases, and a 4-bit-ring instance for wrap and fill saturation.
module tb_fir_lane_seq;

  localparam logic [15:0] MASK = 16'hA5C3;

  logic        clk1;
  logic        rst;
  logic        flush;
  logic [11:0] cfg_tap_len;
  logic [3:0]  cfg_shift;
  logic        s_valid;
  logic [15:0] s_data;
  logic        m_ready;
  logic        sel;
  logic [15:0] cyc = '0;
  logic [15:0] pcm_out;

  logic        a_s_ready, a_m_valid, a_m_warm, a_pcm_in_wr, a_fir_start;
  logic [15:0] a_m_data, a_pcm_in;
  logic [8:0]  a_addr;
  logic [3:0]  a_shift;
  logic [11:0] a_tap_len;

  logic        b_s_ready, b_m_valid, b_m_warm, b_pcm_in_wr, b_fir_start;
  logic [15:0] b_m_data, b_pcm_in;
  logic [3:0]  b_addr;
  logic [3:0]  b_shift;
  logic [11:0] b_tap_len;

  int errors = 0;
  int checks = 0;

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Lane result stand-in: a known function of the cycle number, so the
  // captured value pins down the capture cycle.
  always @(posedge clk1) cyc <= cyc + 16'd1;
  assign pcm_out = cyc ^ MASK;

  fir_lane_seq #(.PCMAW(9), .MUL_NUM(2), .FIR_LAT(8)) dut_a (
    .clk1(clk1), .rst(rst), .flush(flush),
    .cfg_tap_len(cfg_tap_len), .cfg_shift(cfg_shift),
    .s_valid(s_valid & ~sel), .s_data(s_data), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_data(a_m_data), .m_warm(a_m_warm), .m_ready(m_ready),
    .pcm_in_wr(a_pcm_in_wr), .pcm_in(a_pcm_in), .pcm_in_address(a_addr),
    .pcm_out_shift(a_shift), .tap_len(a_tap_len), .fir_start(a_fir_start),
    .pcm_out(pcm_out)
  );

  fir_lane_seq #(.PCMAW(4), .MUL_NUM(2), .FIR_LAT(8)) dut_b (
    .clk1(clk1), .rst(rst), .flush(flush),
    .cfg_tap_len(cfg_tap_len), .cfg_shift(cfg_shift),
    .s_valid(s_valid & sel), .s_data(s_data), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_data(b_m_data), .m_warm(b_m_warm), .m_ready(m_ready),
    .pcm_in_wr(b_pcm_in_wr), .pcm_in(b_pcm_in), .pcm_in_address(b_addr),
    .pcm_out_shift(b_shift), .tap_len(b_tap_len), .fir_start(b_fir_start),
    .pcm_out(pcm_out)
  );

  wire        x_s_ready   = sel ? b_s_ready   : a_s_ready;
  wire        x_m_valid   = sel ? b_m_valid   : a_m_valid;
  wire        x_m_warm    = sel ? b_m_warm    : a_m_warm;
  wire        x_pcm_in_wr = sel ? b_pcm_in_wr : a_pcm_in_wr;
  wire        x_fir_start = sel ? b_fir_start : a_fir_start;
  wire [15:0] x_m_data    = sel ? b_m_data    : a_m_data;
  wire [15:0] x_pcm_in    = sel ? b_pcm_in    : a_pcm_in;
  wire [8:0]  x_addr      = sel ? {5'd0, b_addr} : a_addr;
  wire [3:0]  x_shift     = sel ? b_shift     : a_shift;
  wire [11:0] x_tap_len   = sel ? b_tap_len   : a_tap_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, write, start, run, result and handshake.
  task automatic send(input logic [15:0] data, input logic [11:0] tap,
                      input logic [3:0] shf, input logic [8:0] exp_addr,
                      input logic [11:0] exp_eff, input int exp_l,
                      input logic exp_warm, input int hold, input bit pulse_flush);
    int          k;
    int          waited;
    logic [15:0] t_cyc;
    logic [15:0] held;
    logic [15:0] exp_data;
    bit          stable;
    bit          fs_ok;
    s_data      = data;
    cfg_tap_len = tap;
    cfg_shift   = shf;
    s_valid     = 1'b1;
    waited      = 0;
    while (!x_s_ready && waited < 50) begin
      @(negedge clk1);
      waited++;
    end
    check("accept_ready", x_s_ready, 1);
    t_cyc = cyc;
    @(negedge clk1);
    s_valid   = 1'b0;
    s_data    = ~data;
    cfg_shift = ~shf;
    check("wr_strobe", x_pcm_in_wr, 1);
    check("wr_data", x_pcm_in, data);
    check("wr_addr", x_addr, exp_addr);
    check("start_low_in_write", x_fir_start, 0);
    @(negedge clk1);
    check("start_rise", x_fir_start, 1);
    check("tap_len", x_tap_len, exp_eff);
    k     = 2;
    fs_ok = 1'b1;
    do begin
      @(negedge clk1);
      k++;
      flush = pulse_flush && (k == 4);
      if (!x_m_valid && !x_fir_start) fs_ok = 1'b0;
    end while (!x_m_valid && k < 600);
    flush = 1'b0;
    exp_data = (t_cyc + 16'(2 + exp_l)) ^ MASK;
    check("start_held", fs_ok, 1);
    check("latency", k, 3 + exp_l);
    check("m_data", x_m_data, exp_data);
    check("m_warm", x_m_warm, exp_warm);
    check("start_low_in_hold", x_fir_start, 0);
    check("shift", x_shift, shf);
    check("addr_stable", x_addr, exp_addr);
    held   = x_m_data;
    stable = 1'b1;
    if (hold > 0) m_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      if (!x_m_valid || x_m_data !== held || x_m_warm !== exp_warm) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    m_ready = 1'b1;
    @(negedge clk1);
    check("m_valid_drop", x_m_valid, 0);
  endtask

  initial begin
    int waited;
    rst         = 1'b1;
    flush       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    cfg_tap_len = '0;
    cfg_shift   = '0;
    m_ready     = 1'b1;
    sel         = 1'b0;
    repeat (3) @(negedge clk1);

    check("rst_s_ready", a_s_ready, 1);
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_m_warm", a_m_warm, 0);
    check("rst_pcm_in_wr", a_pcm_in_wr, 0);
    check("rst_pcm_in", a_pcm_in, 0);
    check("rst_addr", a_addr, 0);
    check("rst_fir_start", a_fir_start, 0);
    check("rst_tap_len", a_tap_len, 1);
    check("rst_shift", a_shift, 0);
    check("rst_b_s_ready", b_s_ready, 1);
    rst = 1'b0;
    @(negedge clk1);

    // tap 64: run length 32 + 8 - 1 = 39, m_valid at accept + 42.
    send(16'h1234, 12'd64, 4'd3, 9'd0, 12'd64, 39, 1'b0, 0, 1'b0);
    check("ptr_after_first", a_addr, 1);

    flush = 1'b1;
    @(negedge clk1);
    flush = 1'b0;
    check("idle_flush_addr", a_addr, 0);

    // Warm-up: tap 4, run length 2 + 7 = 9.
    for (int i = 0; i < 4; i++)
      send(16'h0100 + 16'(i), 12'd4, 4'd1, 9'(i), 12'd4, 9, (i == 3), 0, 1'b0);

    // Clamps: 0 -> 1 (run 8), 4095 -> 511 (run 256 + 7 = 263).
    send(16'hBEEF, 12'd0, 4'd2, 9'd4, 12'd1, 8, 1'b1, 0, 1'b0);
    send(16'h7FFF, 12'd4095, 4'd5, 9'd5, 12'd511, 263, 1'b0, 0, 1'b0);

    // Flush during RUN with back-pressure; result still completes.
    send(16'h8001, 12'd4, 4'd6, 9'd6, 12'd4, 9, 1'b1, 10, 1'b1);
    check("flush_pend_ready", a_s_ready, 0);
    @(negedge clk1);
    check("flush_applied_ready", a_s_ready, 1);
    check("flush_applied_addr", a_addr, 0);
    send(16'h4444, 12'd4, 4'd0, 9'd0, 12'd4, 9, 1'b0, 0, 1'b0);

    // Reset while the lane is running.
    check("pre_abort_ready", a_s_ready, 1);
    s_data      = 16'hDEAD;
    cfg_tap_len = 12'd4;
    s_valid     = 1'b1;
    @(negedge clk1);
    s_valid = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    check("abort_running", a_fir_start, 1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    check("abort_fir_start", a_fir_start, 0);
    check("abort_m_valid", a_m_valid, 0);
    check("abort_s_ready", a_s_ready, 1);
    waited = 0;
    while (waited < 5) begin
      @(negedge clk1);
      waited++;
    end
    check("abort_no_output", a_m_valid, 0);
    send(16'h5555, 12'd4, 4'd0, 9'd0, 12'd4, 9, 1'b0, 0, 1'b0);

    // 16-entry ring: tap 16 clamps to 15, run length 8 + 7 = 15.
    sel = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(16'h2000 + 16'(i), 12'd16, 4'd0, 9'(i % 16), 12'd15, 15, (i >= 14), 0, 1'b0);
      check("fill", dut_b.fill, (i + 1 > 15) ? 15 : i + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
